// File: rtl/burst_memory_pkg.sv
// Shared types and helpers for the burst memory: FSM states, beat-counter
// width and the modulo-DEPTH address step.
package burst_memory_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  // Beat counter holds len+1, which needs one bit more than the len field.
  function automatic int cnt_width(input int len_w);
    return len_w + 1;
  endfunction

  // Steps to the next word; DEPTH-1 rolls to 0 regardless of the address width.
  function automatic logic [31:0] next_addr(input logic [31:0] cur, input logic [31:0] depth);
    return (cur >= depth - 32'd1) ? 32'd0 : cur + 32'd1;
  endfunction

endpackage

// File: rtl/burst_memory_mem_array.sv
// DEPTH x WIDTH word store: synchronous byte-strobed write, combinational read.
module mem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int ADDR  = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR-1:0]      waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [WIDTH/8-1:0]   wstrb,
  input  logic [ADDR-1:0]      raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;
  logic             rd_ok;

  // Only a partially populated address space needs a bounds guard.
  generate
    if (DEPTH == (1 << ADDR)) begin : g_full
      assign wr_ok = 1'b1;
      assign rd_ok = 1'b1;
    end else begin : g_part
      assign wr_ok = 32'(waddr) < 32'(DEPTH);
      assign rd_ok = 32'(raddr) < 32'(DEPTH);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (we && wr_ok) begin
      for (int i = 0; i < WIDTH/8; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = rd_ok ? mem[raddr] : '0;

endmodule

// File: rtl/burst_memory.sv
// Burst word memory: one command per burst, write/read beats at up to one per
// cycle, byte strobes, optional wrap at DEPTH, registered read with back-pressure.
module burst_memory
  import burst_memory_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int ADDR  = 8,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  output logic               ready,
  input  logic               wrbar,
  input  logic [ADDR-1:0]    addr,
  input  logic [LEN_W-1:0]   len,
  input  logic               wrap,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wstrb,
  input  logic               wvalid,
  output logic               wready,
  output logic [WIDTH-1:0]   rdata,
  output logic               rvalid,
  input  logic               rready,
  output logic               rlast,
  output logic               done,
  output logic               err
);

  localparam int CNT_W = cnt_width(LEN_W);
  localparam int SUM_W = ADDR + LEN_W + 1;

  state_t           state_q, state_d;
  logic             ready_q;
  logic             err_q;
  logic [ADDR-1:0]  cur_q;
  logic [CNT_W-1:0] cnt_q;      // beats left, including the one in flight
  logic [WIDTH-1:0] rdata_q;
  logic             rvalid_q;
  logic             rlast_q;

  logic             accept;
  logic             beat_w;
  logic             beat_r;
  logic             range_err;
  logic [SUM_W-1:0] end_addr;
  logic [ADDR-1:0]  raddr;
  logic [ADDR-1:0]  cur_next;
  logic [WIDTH-1:0] mem_rdata;

  assign end_addr  = SUM_W'(addr) + SUM_W'(len);
  assign range_err = !wrap && ((end_addr > SUM_W'(DEPTH - 1)) || (SUM_W'(addr) >= SUM_W'(DEPTH)));
  assign cur_next  = ADDR'(next_addr(32'(cur_q), 32'(DEPTH)));
  // First read beat is fetched straight from the command address at accept.
  assign raddr     = (state_q == IDLE) ? addr : cur_q;

  mem_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) u_mem (
    .clk   (clk),
    .we    (beat_w && rst),
    .waddr (cur_q),
    .wdata (wdata),
    .wstrb (wstrb),
    .raddr (raddr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    beat_w  = 1'b0;
    beat_r  = 1'b0;
    wready  = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      IDLE: begin
        accept = valid && ready_q;
        if (accept) state_d = range_err ? RESP : (wrbar ? WRITE : READ);
      end
      WRITE: begin
        wready = 1'b1;
        beat_w = wvalid;
        if (wvalid && cnt_q == CNT_W'(1)) state_d = RESP;
      end
      READ: begin
        beat_r = rvalid_q && rready;
        if (beat_r && rlast_q) state_d = RESP;
      end
      RESP: begin
        done    = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q    <= 1'b0;
      cur_q    <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else if (accept) begin
      err_q <= range_err;
      cnt_q <= CNT_W'(len) + CNT_W'(1);
      if (!range_err && !wrbar) begin
        rdata_q  <= mem_rdata;
        rvalid_q <= 1'b1;
        rlast_q  <= (len == '0);
        cur_q    <= ADDR'(next_addr(32'(addr), 32'(DEPTH)));
      end else begin
        cur_q <= addr;
      end
    end else if (beat_w) begin
      cur_q <= cur_next;
      cnt_q <= cnt_q - CNT_W'(1);
    end else if (beat_r) begin
      if (rlast_q) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end else begin
        // Reload on the handshake edge so beats flow without a bubble.
        rdata_q <= mem_rdata;
        rlast_q <= (cnt_q == CNT_W'(2));
        cur_q   <= cur_next;
        cnt_q   <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign ready  = ready_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign rlast  = rlast_q;

endmodule

// File: tb/tb_burst_memory.sv
// Randomized bench for burst_memory against an array-based memory model.
module tb_burst_memory;

  localparam int WIDTH = 32;
  localparam int DEPTH = 256;
  localparam int ADDR  = 8;
  localparam int LEN_W = 8;
  localparam int SW    = WIDTH / 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             valid = 1'b0;
  logic             wrbar = 1'b0;
  logic             wrap = 1'b0;
  logic             wvalid = 1'b0;
  logic             rready = 1'b0;
  logic [ADDR-1:0]  addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic [WIDTH-1:0] wdata = '0;
  logic [SW-1:0]    wstrb = '0;
  logic             ready, wready, rvalid, rlast, done, err;
  logic [WIDTH-1:0] rdata;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] model [DEPTH];
  logic [WIDTH-1:0] wq_d [$];
  logic [SW-1:0]    wq_s [$];
  bit               rpat [$];

  always #5 clk = ~clk;

  burst_memory #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready), .wrbar(wrbar),
    .addr(addr), .len(len), .wrap(wrap), .wdata(wdata), .wstrb(wstrb),
    .wvalid(wvalid), .wready(wready), .rdata(rdata), .rvalid(rvalid),
    .rready(rready), .rlast(rlast), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_w(input logic [WIDTH-1:0] d, input logic [SW-1:0] s);
    wq_d.push_back(d);
    wq_s.push_back(s);
  endtask

  task automatic issue(input logic wr, input int a, input int l, input logic w);
    int n = 0;
    @(negedge clk);
    valid = 1'b1; wrbar = wr; addr = ADDR'(a); len = LEN_W'(l); wrap = w;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready", 64'(ready), 64'(1));
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic finish_resp();
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("ready_back", 64'(ready), 64'(1));
  endtask

  task automatic do_write(input int a, input int l, input logic w);
    int  cur = a;
    bit  exp_err = !w && (a + l > DEPTH - 1);
    issue(1'b1, a, l, w);
    if (exp_err) begin
      chk("werr_done", 64'(done), 64'(1));
      chk("werr_err", 64'(err), 64'(1));
      chk("werr_wready", 64'(wready), 64'(0));
      wq_d.delete();
      wq_s.delete();
    end else begin
      for (int b = 0; b <= l; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          wvalid = 1'b0;
          @(posedge clk); #1;
        end
        wvalid = 1'b1;
        wdata  = wq_d.pop_front();
        wstrb  = wq_s.pop_front();
        chk("w_wready", 64'(wready), 64'(1));
        chk("w_ready_low", 64'(ready), 64'(0));
        @(posedge clk); #1;
        for (int i = 0; i < SW; i++)
          if (wstrb[i]) model[cur][8*i +: 8] = wdata[8*i +: 8];
        cur = (cur + 1) % DEPTH;
      end
      wvalid = 1'b0;
      chk("w_done", 64'(done), 64'(1));
      chk("w_err", 64'(err), 64'(0));
      chk("w_wready_off", 64'(wready), 64'(0));
    end
    finish_resp();
  endtask

  task automatic do_read(input int a, input int l, input logic w);
    int cur = a;
    int beats = 0;
    int cyc = 0;
    bit hs;
    bit exp_err = !w && (a + l > DEPTH - 1);
    issue(1'b0, a, l, w);
    if (exp_err) begin
      chk("rerr_done", 64'(done), 64'(1));
      chk("rerr_err", 64'(err), 64'(1));
      chk("rerr_rvalid", 64'(rvalid), 64'(0));
    end else begin
      while (beats <= l && cyc < 200) begin
        rready = (rpat.size() != 0) ? rpat.pop_front() : 1'($urandom_range(0, 1));
        chk("r_valid", 64'(rvalid), 64'(1));
        chk("r_data", 64'(rdata), 64'(model[cur]));
        chk("r_last", 64'(rlast), 64'(beats == l));
        hs = rvalid && rready;
        @(posedge clk); #1;
        if (hs) begin
          beats++;
          cur = (cur + 1) % DEPTH;
        end
        cyc++;
      end
      rready = 1'b0;
      chk("r_beats", 64'(beats), 64'(l + 1));
      chk("r_done", 64'(done), 64'(1));
      chk("r_err", 64'(err), 64'(0));
      chk("r_valid_off", 64'(rvalid), 64'(0));
    end
    finish_resp();
  endtask

  initial begin
    // Reset held with a pending command.
    rst = 1'b0; valid = 1'b1; wrbar = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_ready", 64'(ready), 64'(0));
      chk("rst_wready", 64'(wready), 64'(0));
      chk("rst_rvalid", 64'(rvalid), 64'(0));
      chk("rst_rlast", 64'(rlast), 64'(0));
      chk("rst_rdata", 64'(rdata), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
    end
    valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", 64'(ready), 64'(1));
    chk("rel_wready", 64'(wready), 64'(0));

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) push_w(WIDTH'($urandom), '1);
    do_write(0, DEPTH - 1, 1'b0);

    // Write then read back four words.
    push_w(32'h11111111, 4'hF); push_w(32'h22222222, 4'hF);
    push_w(32'h33333333, 4'hF); push_w(32'h44444444, 4'hF);
    do_write(16, 3, 1'b0);
    for (int i = 0; i < 8; i++) rpat.push_back(1'b1);
    do_read(16, 3, 1'b0);
    rpat.delete();

    // Byte strobes.
    push_w(32'hAABBCCDD, 4'hF);
    do_write(32, 0, 1'b0);
    push_w(32'h11223344, 4'b0101);
    do_write(32, 0, 1'b0);
    do_read(32, 0, 1'b0);

    // Wrap past the top of memory.
    for (int i = 0; i < 4; i++) push_w(WIDTH'($urandom), '1);
    do_write(254, 3, 1'b1);
    do_read(254, 3, 1'b1);

    // Same range without wrap is rejected; word 0 must survive.
    for (int i = 0; i < 4; i++) push_w(WIDTH'($urandom), '1);
    do_write(254, 3, 1'b0);
    do_read(254, 3, 1'b0);
    do_read(0, 1, 1'b0);

    // Read back-pressure pattern.
    rpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    do_read(16, 3, 1'b0);
    rpat.delete();

    // Reset in the middle of a write burst.
    for (int i = 0; i < 4; i++) push_w(WIDTH'($urandom), '1);
    issue(1'b1, 64, 3, 1'b0);
    for (int b = 0; b < 2; b++) begin
      wvalid = 1'b1; wdata = wq_d.pop_front(); wstrb = wq_s.pop_front();
      @(posedge clk); #1;
      model[64 + b] = wdata;
    end
    wdata = wq_d.pop_front(); wstrb = wq_s.pop_front();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_wready", 64'(wready), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_ready", 64'(ready), 64'(0));
    wvalid = 1'b0; wq_d.delete(); wq_s.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_ready", 64'(ready), 64'(1));
    chk("mid_rel_done", 64'(done), 64'(0));
    do_read(64, 3, 1'b0);

    // Random bursts.
    for (int k = 0; k < 24; k++) begin
      int  a = $urandom_range(0, DEPTH - 1);
      int  l = $urandom_range(0, 7);
      bit  w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= l; i++) push_w(WIDTH'($urandom), SW'($urandom_range(0, 15)));
        do_write(a, l, w);
      end else begin
        do_read(a, l, w);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/burst_memory.md
Name: burst_memory

Overview:
- Parametrised single-port word memory behind a command/data handshake.
- Generalises the single-beat valid/ready memory to multi-beat bursts with byte strobes, address wrap-around and read back-pressure.
- Sits as a slave store under a bus bridge or DMA.
- One command is accepted per burst; beats then stream at up to one per cycle.

Parameters:
WIDTH, 32, data word width in bits; must be a multiple of 8.
DEPTH, 256, number of words; DEPTH <= 2**ADDR.
ADDR, 8, address width.
LEN_W, 8, burst length field width; beats = len+1.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-low reset.
valid  in  1  command valid.
ready  out  1  command accept; high only in IDLE.
wrbar  in  1  command type; 1 = write, 0 = read.
addr  in  ADDR  burst start word address.
len  in  LEN_W  beats minus one.
wrap  in  1  1 = address wraps DEPTH-1 -> 0; 0 = crossing is an error.
wdata  in  WIDTH  write beat data.
wstrb  in  WIDTH/8  per-byte write enable.
wvalid  in  1  write beat valid.
wready  out  1  write beat accept.
rdata  out  WIDTH  read beat data.
rvalid  out  1  read beat valid.
rready  in  1  read beat accept.
rlast  out  1  marks the final read beat.
done  out  1  one-cycle pulse at burst end.
err  out  1  valid with done; 1 = burst rejected.

Behaviour:
- Reset (rst=0 at an edge): every output is 0 and the state is IDLE; memory contents are not cleared.
  - ready=1 from the first cycle after rst returns to 1.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE: ready=1. valid&&ready at an edge latches addr, len, wrbar and wrap, sets beat count = len+1, and clears ready.
- Range check at accept, computed in ADDR+LEN_W+1 bits:
  - wrap=0 and addr+len > DEPTH-1 -> go to RESP with err=1. No memory access occurs and no wready/rvalid is raised.
  - addr >= DEPTH is treated the same way when wrap=0.
- Address step: cur+1. With wrap=1, DEPTH-1 steps to 0; the rule is modulo DEPTH, not 2**ADDR.
- WRITE: wready=1.
  - On each wvalid&&wready edge, byte i of mem[cur] is written from wdata[8i+7:8i] where wstrb[i]=1. Bytes with strobe 0 are kept.
  - wstrb=0 consumes the beat but changes nothing.
  - After the last beat: wready=0 and the FSM goes to RESP.
- READ:
  - The first beat is registered, so rvalid=1 with rdata=mem[start] in the cycle after accept.
  - On rvalid&&rready, the next word is loaded at the same edge, giving no bubble (1 beat/cycle).
  - While rvalid&&!rready, rdata and rlast hold stable.
  - rlast=1 exactly on the final beat. After it is accepted: rvalid=0 and the FSM goes to RESP.
- RESP: done=1 for one cycle, err as decided; ready=0. Next state is IDLE, with ready=1 in the following cycle.
- Minimum cost of a 1-beat write with wvalid already high: accept edge N, beat edge N+1, done in cycle N+2, ready in cycle N+3.
- Only one burst is in flight at a time; valid outside IDLE is ignored (not queued).
- Reset mid-burst: the burst is aborted immediately. Remaining beats are not written, and rvalid/wready/done drop on the reset edge.
- Read and write never occur in the same cycle.

Decomposition:
- Package burst_memory_pkg holds:
  - the state enum (IDLE, WRITE, READ, RESP);
  - the beat-counter width constant (LEN_W+1);
  - a next_addr helper (wrap modulo DEPTH).
- Sub-module mem_array holds the DEPTHxWIDTH storage:
  - synchronous byte-strobed write;
  - combinational read port;
  - the read register lives in the controller.

Test Plan:
- Reset: hold rst=0 for 2 cycles while valid=1 -> ready/wready/rvalid/done/err all 0. After release, ready=1 in the next cycle and no access occurs.
- Write then read: write burst addr=0x10, len=3, data 0x11111111/0x22222222/0x33333333/0x44444444, wstrb=0xF. Then read addr=0x10, len=3 with rready=1 -> same 4 words on consecutive cycles, rlast only on the 4th, one done pulse with err=0 per burst.
- Byte strobes: write 0xAABBCCDD at 0x20, then 0x11223344 with wstrb=4'b0101 -> read 0xAA22CC44.
- Wrap: addr=0xFE, len=3, wrap=1 writes 0xFE, 0xFF, 0x00, 0x01, confirmed by read-back.
- Range error: the same command with wrap=0 -> done=1, err=1 one cycle after accept, wready never high, and mem[0x00] is unchanged.
- Back-pressure: read burst len=3 with rready pattern 1,0,0,1,1,0,1 -> rdata held during stalls, exactly 4 beats with no loss or duplication, rlast on the 4th.
- Reset mid-burst: write len=3, drive rst=0 after 2 beats -> words 3 and 4 keep their old values, no done pulse, ready=1 after release.
